// File: rtl/data_sram_like_responder.sv
// Responder end of the data-side SRAM-like interface. Requests are accepted
// with an addr_ok handshake. Each request accesses the internal word memory
// on the edge that accepts it. The bench then gets one in-order data_ok pulse
// per request, after a fixed number of unstalled cycles.
module data_sram_like_responder #(
  parameter int AW    = 10,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AGE_W = $clog2(LAT + 1);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LAT);

  logic [31:0]      mem_q [2**AW];
  logic [3:0]       mem_we;
  logic [AW-1:0]    word_idx;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      ent_rdata_q [DEPTH];
  logic [31:0]      ent_rdata_d [DEPTH];
  logic [AGE_W-1:0] ent_age_q [DEPTH];
  logic [AGE_W-1:0] ent_age_d [DEPTH];

  logic push, pop, head_valid;

  // The size field, the address bits above the memory and the byte offset do
  // not affect the access. Byte lanes come from wstrb alone.
  logic unused_ok;
  assign unused_ok = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  assign word_idx   = data_sram_addr[AW+1:2];
  assign head_valid = (count_q != '0);

  // Handshake and response are derived from queue state only. addr_ok is
  // held low during reset.
  assign data_sram_addr_ok = resetn & (count_q < DEPTH_C);
  assign data_sram_data_ok = head_valid & (ent_age_q[head_q] == AGE_MAX) & ~stall;
  assign data_sram_rdata   = data_sram_data_ok ? ent_rdata_q[head_q] : 32'h0;

  assign push   = data_sram_req & data_sram_addr_ok;
  assign pop    = data_sram_data_ok;
  assign mem_we = {4{push & data_sram_wr}} & data_sram_wstrb;

  // Write the enabled byte lanes of the addressed word at the acceptance edge.
  // NOTE: memory has no reset; clearing 2^AW words would cost a reset fan-out
  // for contents nobody may rely on.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) mem_q[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  // Next-state for pointers, count and entry ages/data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ent_rdata_d = ent_rdata_q;
    ent_age_d   = ent_age_q;

    // Ages advance only on unstalled edges and stop at LAT. Aging the
    // empty slots as well is harmless because a push overwrites their age.
    for (int i = 0; i < DEPTH; i++) begin
      if (!stall && ent_age_q[i] != AGE_MAX) ent_age_d[i] = ent_age_q[i] + AGE_W'(1);
    end

    // A read captures the word before this edge's write lands. Only one
    // request is accepted per edge, so earlier writes are already visible.
    if (push) begin
      ent_rdata_d[tail_q] = data_sram_wr ? 32'h0 : mem_q[word_idx];
      ent_age_d[tail_q]   = AGE_W'(1);
      tail_d              = tail_q + PTR_W'(1);
    end

    if (pop) head_d = head_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers. Reset empties the queue and drops pending responses.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rdata_q[i] <= '0;
        ent_age_q[i]   <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ent_rdata_q <= ent_rdata_d;
      ent_age_q   <= ent_age_d;
    end
  end

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Self-checking bench for data_sram_like_responder. The reference model keeps
// the memory and a queue of pending responses. Each pending response counts
// the unstalled edges seen since its acceptance. Every cycle the bench checks
// addr_ok, data_ok and rdata against that model. Directed sequences are
// followed by a randomized phase.
module tb_data_sram_like_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr, stall;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  data_sram_like_responder #(.AW(AW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wstrb   (wstrb),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .stall             (stall)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    bit          known;
    int          age;     // unstalled edges since acceptance, counting it as 1
    int          acc_cyc;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] ref_mem [int];
  logic [3:0]  ref_kn  [int];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic rst_level;

  // Observations from the most recent step.
  logic        got_aok, got_dok, accepted;
  logic [31:0] resp_log[$];
  int          lat_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, then advance the
  // model across the following rising edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d, input logic st);
    logic exp_aok, exp_dok;
    int   idx;
    logic [31:0] cur;
    logic [3:0]  kn;
    @(negedge clk);
    resetn = rst_level;
    req = r; wr = w; addr = a; wstrb = s; wdata = d; stall = st;
    size = $urandom_range(0, 2);
    if (!rst_level) pend.delete();
    #2;
    exp_aok = rst_level && (pend.size() < DEPTH);
    exp_dok = (pend.size() > 0) && (pend[0].age >= LAT) && !st;
    check("addr_ok", {31'b0, addr_ok}, {31'b0, exp_aok});
    check("data_ok", {31'b0, data_ok}, {31'b0, exp_dok});
    if (exp_dok) begin
      if (pend[0].known) check("rdata", rdata, pend[0].data);
    end else begin
      check("rdata_idle", rdata, 32'h0);
    end
    got_aok = addr_ok;
    got_dok = data_ok;
    if (data_ok) resp_log.push_back(rdata);
    if (exp_dok) begin
      lat_log.push_back(cyc - pend[0].acc_cyc);
      void'(pend.pop_front());
    end
    if (!st) foreach (pend[i]) pend[i].age++;
    accepted = r && exp_aok;
    if (accepted) begin
      idx = int'((a >> 2) & ((32'd1 << AW) - 1));
      if (w) begin
        cur = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        kn  = ref_kn.exists(idx)  ? ref_kn[idx]  : 4'h0;
        for (int i = 0; i < 4; i++) begin
          if (s[i]) begin
            cur[8*i +: 8] = d[8*i +: 8];
            kn[i] = 1'b1;
          end
        end
        ref_mem[idx] = cur;
        ref_kn[idx]  = kn;
        pend.push_back('{data: 32'h0, known: 1'b1, age: 1, acc_cyc: cyc});
      end else begin
        pend.push_back('{data: ref_mem.exists(idx) ? ref_mem[idx] : 32'h0,
                         known: ref_kn.exists(idx) && ref_kn[idx] == 4'hF,
                         age: 1, acc_cyc: cyc});
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // Hold a read request until accepted, bounded by a cycle budget.
  task automatic read_until_accepted(input logic [31:0] a, input int budget);
    int k = 0;
    do begin
      step(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0);
      k++;
    end while (!accepted && k < budget);
    check("accept_within_budget", {31'b0, accepted}, 32'h1);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wstrb = '0;
    wdata = '0; stall = 1'b0; size = '0;

    // Reset then idle.
    rst_level = 1'b0;
    idle(3);
    check("aok_in_reset", {31'b0, got_aok}, 32'h0);
    rst_level = 1'b1;
    resp_log.delete();
    idle(20);
    check("aok_after_reset", {31'b0, got_aok}, 32'h1);
    check("idle_no_resp", resp_log.size(), 0);

    // Full-word write then read.
    resp_log.delete(); lat_log.delete();
    step(1'b1, 1'b1, 32'h100, 4'hF, 32'h12345678, 1'b0);
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    idle(5);
    check("wr_rd_count", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      check("wr_rdata", resp_log[0], 32'h0);
      check("rd_rdata", resp_log[1], 32'h12345678);
      check("rd_latency", lat_log[1], LAT);
    end

    // Byte write into lane 1, then read the merged word.
    resp_log.delete();
    step(1'b1, 1'b1, 32'h101, 4'h2, 32'h0000AB00, 1'b0);
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    idle(5);
    check("byte_merge_count", resp_log.size(), 2);
    if (resp_log.size() == 2) check("byte_merge", resp_log[1], 32'h1234AB78);

    // Fill under stall: four accepted, fifth refused until a pop.
    resp_log.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1);
      check("stall_accept", {31'b0, accepted}, 32'h1);
    end
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1);
    check("full_aok", {31'b0, got_aok}, 32'h0);
    read_until_accepted(32'h100, 10);
    idle(8);
    check("stall_drain_count", resp_log.size(), 5);
    foreach (resp_log[i]) check("stall_drain_data", resp_log[i], 32'h1234AB78);

    // Address wrap: 0x1000 and 0x0000 name the same word.
    resp_log.delete();
    step(1'b1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0);
    step(1'b1, 1'b0, 32'h0003, 4'h0, 32'h0, 1'b0);
    idle(5);
    check("wrap_count", resp_log.size(), 2);
    if (resp_log.size() == 2) check("wrap_data", resp_log[1], 32'hCAFEF00D);

    // Reset with three pending responses.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1);
    resp_log.delete();
    rst_level = 1'b0;
    idle(2);
    rst_level = 1'b1;
    idle(6);
    check("reset_drops_pending", resp_log.size(), 0);
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    idle(4);
    check("post_reset_count", resp_log.size(), 1);
    if (resp_log.size() == 1) check("post_reset_data", resp_log[0], 32'h1234AB78);

    // Randomized traffic over a small pool of words with random upper bits.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 2) | ($urandom & 32'hFFFF_F000) | $urandom_range(0, 3);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, a,
           4'($urandom), $urandom, $urandom_range(0, 3) == 0);
    end
    idle(20);
    check("final_empty", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
